// File: rtl/spi_slave_fsm_if.sv
// Bus between an SPI slave front-end FSM and whatever drives it.
// The conditioned SPI inputs and the data-memory port are bundled here.
// The "master" side is the environment (conditioner + memory).
interface spi_slave_fsm_if #(
    parameter int datawidth = 8
);
    logic                 cs_cond;
    logic                 sclk_posedge;
    logic                 sclk_negedge;
    logic                 mosi_cond;
    logic [datawidth-1:0] dm_rdata;
    logic [datawidth-2:0] dm_addr;
    logic [datawidth-1:0] dm_wdata;
    logic                 dm_we;
    logic                 miso;
    logic                 miso_oe;
    logic                 busy;

    modport slave (
        input  cs_cond,
        input  sclk_posedge,
        input  sclk_negedge,
        input  mosi_cond,
        input  dm_rdata,
        output dm_addr,
        output dm_wdata,
        output dm_we,
        output miso,
        output miso_oe,
        output busy
    );

    modport master (
        output cs_cond,
        output sclk_posedge,
        output sclk_negedge,
        output mosi_cond,
        output dm_rdata,
        input  dm_addr,
        input  dm_wdata,
        input  dm_we,
        input  miso,
        input  miso_oe,
        input  busy
    );
endinterface

// File: rtl/spi_slave_fsm.sv
// SPI slave frame FSM: collects an address + R/W bit, then either shifts
// memory read data out on MISO or collects a data word and issues a
// single-cycle memory write. Chip select high always returns to IDLE.
module spi_slave_fsm #(
    parameter int datawidth = 8
) (
    input  logic              clk,
    input  logic              reset,
    spi_slave_fsm_if.slave    bus
);
    localparam int CW = $clog2(datawidth + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(datawidth - 1);

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        LATCH_ADDR,
        READ_WAIT,
        READ_SHIFT,
        WRITE_GET,
        WRITE_STORE,
        DONE
    } state_t;

    state_t               state;
    logic [datawidth-1:0] shift_reg;
    logic [CW-1:0]        bit_cnt;
    logic [datawidth-2:0] addr_reg;
    logic [datawidth-1:0] wdata_reg;
    logic                 we_reg;
    logic                 miso_oe_reg;
    logic                 busy_reg;
    logic [datawidth-1:0] shift_in;

    // MOSI bit appended at the LSB, word moves toward the MSB
    assign shift_in = {shift_reg[datawidth-2:0], bus.mosi_cond};

    assign bus.dm_addr  = addr_reg;
    assign bus.dm_wdata = wdata_reg;
    assign bus.dm_we    = we_reg;
    assign bus.miso_oe  = miso_oe_reg;
    assign bus.miso     = miso_oe_reg & shift_reg[datawidth-1];
    assign bus.busy     = busy_reg;

    // Frame sequencing; chip select high overrides every other transition
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            shift_reg   <= '0;
            bit_cnt     <= '0;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            we_reg      <= 1'b0;
            miso_oe_reg <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            we_reg <= 1'b0;
            if (bus.cs_cond) begin
                state       <= IDLE;
                shift_reg   <= '0;
                bit_cnt     <= '0;
                miso_oe_reg <= 1'b0;
                busy_reg    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state     <= GET_ADDR;
                        shift_reg <= '0;
                        bit_cnt   <= '0;
                        busy_reg  <= 1'b1;
                    end
                    GET_ADDR: begin
                        if (bus.sclk_posedge) begin
                            shift_reg <= shift_in;
                            bit_cnt   <= bit_cnt + 1'b1;
                            if (bit_cnt == LAST_BIT) begin
                                state <= LATCH_ADDR;
                            end
                        end
                    end
                    LATCH_ADDR: begin
                        addr_reg <= shift_reg[datawidth-1:1];
                        bit_cnt  <= '0;
                        if (shift_reg[0]) begin
                            state <= READ_WAIT;
                        end else begin
                            state     <= WRITE_GET;
                            shift_reg <= '0;
                        end
                    end
                    READ_WAIT: begin
                        if (bus.sclk_negedge) begin
                            shift_reg   <= bus.dm_rdata;
                            bit_cnt     <= '0;
                            miso_oe_reg <= 1'b1;
                            state       <= READ_SHIFT;
                        end
                    end
                    READ_SHIFT: begin
                        if (bus.sclk_negedge) begin
                            shift_reg <= {shift_reg[datawidth-2:0], 1'b0};
                            if (bit_cnt == LAST_BIT) begin
                                miso_oe_reg <= 1'b0;
                                state       <= DONE;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end
                    WRITE_GET: begin
                        if (bus.sclk_posedge) begin
                            shift_reg <= shift_in;
                            bit_cnt   <= bit_cnt + 1'b1;
                            if (bit_cnt == LAST_BIT) begin
                                wdata_reg <= shift_in;
                                we_reg    <= 1'b1;
                                state     <= WRITE_STORE;
                            end
                        end
                    end
                    WRITE_STORE: begin
                        state <= DONE;
                    end
                    DONE: begin
                        state <= DONE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule
